pos_onehot_decoder_q: RTL and testbench

- Inverse of the team's 4-bit lowest-set-bit position encoder: accepts 2-bit bit-position tokens over a valid/ready handshake and emits the matching one-hot vectors.
- Decoded vectors are buffered in a small FIFO. A sticky accumulated mask records every position seen since the last clear.
- Sits downstream of the position encoder. It rebuilds bit vectors for consumers that need masks, not indices.

---
 rtl/pos_onehot_decoder_q_if.sv | 30 +++
 rtl/pos_onehot_decoder_q.sv | 105 ++++++++++
 tb/tb_pos_onehot_decoder_q.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pos_onehot_decoder_q_if.sv
// Token-in / one-hot-out bus for the position decoder, plus its mask and occupancy sideband.
interface pos_onehot_decoder_q_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned POS_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [POS_W-1:0] in_pos;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_onehot;
  logic             out_new;
  logic             out_err;
  logic [N-1:0]     mask;
  logic             mask_clr;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, in_pos, out_ready, mask_clr,
    input  in_ready, out_valid, out_onehot, out_new, out_err, mask, count
  );

  modport slave (
    input  in_valid, in_pos, out_ready, mask_clr,
    output in_ready, out_valid, out_onehot, out_new, out_err, mask, count
  );
endinterface

// File: rtl/pos_onehot_decoder_q.sv
// Decodes bit-position tokens into one-hot vectors buffered in a small FIFO,
// tracking a sticky mask of every position accepted since the last clear.
module pos_onehot_decoder_q #(
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  pos_onehot_decoder_q_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [N-1:0]     oh_mem_q [DEPTH];
  logic [N-1:0]     oh_mem_d [DEPTH];
  logic [DEPTH-1:0] new_mem_q, new_mem_d;
  logic [DEPTH-1:0] err_mem_q, err_mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [N-1:0]     mask_q, mask_d;

  logic             in_ready_c;
  logic             out_valid_c;
  logic             acc;
  logic             pop;
  logic             dec_err;
  logic             dec_new;
  logic [N-1:0]     dec_oh;
  logic [N-1:0]     mask_eff;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign in_ready_c  = (count_q < CW'(DEPTH));
  assign out_valid_c = (count_q != '0);
  assign acc         = bus.in_valid & in_ready_c;
  assign pop         = out_valid_c & bus.out_ready;

  // Decode the incoming token; a same-cycle clear hides the old mask from the new-bit test.
  always_comb begin
    dec_err  = (32'(bus.in_pos) >= N);
    dec_oh   = dec_err ? '0 : (N'(1) << bus.in_pos);
    mask_eff = bus.mask_clr ? '0 : mask_q;
    dec_new  = ~dec_err & ~|(mask_eff & dec_oh);
  end

  always_comb begin
    oh_mem_d  = oh_mem_q;
    new_mem_d = new_mem_q;
    err_mem_d = err_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    mask_d    = mask_eff | (acc ? dec_oh : '0);

    if (acc) begin
      oh_mem_d[wr_ptr_q]  = dec_oh;
      new_mem_d[wr_ptr_q] = dec_new;
      err_mem_d[wr_ptr_q] = dec_err;
      wr_ptr_d            = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({acc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        oh_mem_q[i] <= '0;
      end
      new_mem_q <= '0;
      err_mem_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      mask_q    <= '0;
    end else begin
      oh_mem_q  <= oh_mem_d;
      new_mem_q <= new_mem_d;
      err_mem_q <= err_mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mask_q    <= mask_d;
    end
  end

  // Head fields are forced to zero whenever the FIFO is empty.
  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_c;
  assign bus.out_onehot = out_valid_c ? oh_mem_q[rd_ptr_q] : '0;
  assign bus.out_new    = out_valid_c & new_mem_q[rd_ptr_q];
  assign bus.out_err    = out_valid_c & err_mem_q[rd_ptr_q];
  assign bus.mask       = mask_q;
  assign bus.count      = count_q;
endmodule

// File: tb/tb_pos_onehot_decoder_q.sv
// Directed vector table plus randomized run against a queue-based reference model.
module tb_pos_onehot_decoder_q;
  localparam int unsigned N     = 4;
  localparam int unsigned DEPTH = 2;
  localparam int NSTEP = 29;

  logic clk;
  logic rst_n;

  pos_onehot_decoder_q_if #(.N(N), .DEPTH(DEPTH)) bus ();

  pos_onehot_decoder_q #(.N(N), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cur_step = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %0h expected %0h", name, cur_step, act, exp);
  endtask

  task automatic apply(input logic rst, input logic iv, input logic [1:0] pos,
                       input logic ordy, input logic clr);
    rst_n         = rst;
    bus.in_valid  = iv;
    bus.in_pos    = pos;
    bus.out_ready = ordy;
    bus.mask_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst; logic iv; logic [1:0] pos; logic ordy; logic clr;
    logic [1:0] cnt; logic vld; logic [3:0] oh; logic nw; logic [3:0] msk; logic rdy;
  } vec_t;

  vec_t tbl [NSTEP];

  function automatic vec_t mk(logic rst, logic iv, logic [1:0] pos, logic ordy, logic clr,
                              logic [1:0] cnt, logic vld, logic [3:0] oh, logic nw,
                              logic [3:0] msk, logic rdy);
    vec_t v;
    v.rst = rst; v.iv = iv; v.pos = pos; v.ordy = ordy; v.clr = clr;
    v.cnt = cnt; v.vld = vld; v.oh = oh; v.nw = nw; v.msk = msk; v.rdy = rdy;
    return v;
  endfunction

  // Reference model: a queue of decoded entries and a plain mask variable.
  typedef struct packed { logic [3:0] oh; logic nw; logic er; } ent_t;
  ent_t       mq [$];
  logic [3:0] mmask;

  task automatic model_step(input logic iv, input int pos, input logic ordy, input logic clr);
    ent_t e;
    logic [3:0] base;
    bit acc, pop;
    acc  = iv && (mq.size() < DEPTH);
    pop  = (mq.size() > 0) && ordy;
    base = clr ? 4'b0 : mmask;
    e.er = (pos >= N);
    e.oh = e.er ? 4'b0 : 4'(1 << pos);
    e.nw = !e.er && (((base >> pos) & 4'd1) == 4'd0);
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(e);
    if (acc) mmask = base | e.oh;
    else if (clr) mmask = 4'b0;
  endtask

  task automatic model_check();
    ent_t h;
    h = (mq.size() > 0) ? mq[0] : '0;
    chk("count",     32'(bus.count),      32'(mq.size()));
    chk("out_valid", 32'(bus.out_valid),  32'(mq.size() > 0));
    chk("onehot",    32'(bus.out_onehot), 32'(h.oh));
    chk("out_new",   32'(bus.out_new),    32'(h.nw));
    chk("out_err",   32'(bus.out_err),    32'(h.er));
    chk("mask",      32'(bus.mask),       32'(mmask));
    chk("in_ready",  32'(bus.in_ready),   32'(mq.size() < DEPTH));
  endtask

  initial begin
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.in_pos = '0; bus.out_ready = 1'b0; bus.mask_clr = 1'b0;

    //             rst iv pos ordy clr  cnt vld oh       nw msk      rdy
    tbl[0]  = mk(0, 0, 0, 0, 0,  0, 0, 4'b0000, 0, 4'b0000, 1);
    tbl[1]  = mk(1, 1, 2, 1, 0,  1, 1, 4'b0100, 1, 4'b0100, 1);
    tbl[2]  = mk(1, 0, 0, 1, 0,  0, 0, 4'b0000, 0, 4'b0100, 1);
    tbl[3]  = mk(1, 1, 0, 0, 1,  1, 1, 4'b0001, 1, 4'b0001, 1);
    tbl[4]  = mk(1, 1, 3, 0, 0,  2, 1, 4'b0001, 1, 4'b1001, 0);
    tbl[5]  = mk(1, 1, 1, 0, 0,  2, 1, 4'b0001, 1, 4'b1001, 0);
    tbl[6]  = mk(1, 0, 0, 1, 0,  1, 1, 4'b1000, 1, 4'b1001, 1);
    tbl[7]  = mk(1, 0, 0, 1, 0,  0, 0, 4'b0000, 0, 4'b1001, 1);
    tbl[8]  = mk(1, 0, 0, 0, 1,  0, 0, 4'b0000, 0, 4'b0000, 1);
    tbl[9]  = mk(1, 1, 1, 0, 0,  1, 1, 4'b0010, 1, 4'b0010, 1);
    tbl[10] = mk(1, 1, 1, 0, 0,  2, 1, 4'b0010, 1, 4'b0010, 0);
    tbl[11] = mk(1, 0, 0, 1, 0,  1, 1, 4'b0010, 0, 4'b0010, 1);
    tbl[12] = mk(1, 0, 0, 1, 0,  0, 0, 4'b0000, 0, 4'b0010, 1);
    tbl[13] = mk(1, 1, 0, 1, 0,  1, 1, 4'b0001, 1, 4'b0011, 1);
    tbl[14] = mk(1, 1, 3, 1, 0,  1, 1, 4'b1000, 1, 4'b1011, 1);
    tbl[15] = mk(1, 1, 3, 1, 1,  1, 1, 4'b1000, 1, 4'b1000, 1);
    tbl[16] = mk(1, 0, 0, 1, 0,  0, 0, 4'b0000, 0, 4'b1000, 1);
    tbl[17] = mk(1, 1, 0, 1, 0,  1, 1, 4'b0001, 1, 4'b1001, 1);
    tbl[18] = mk(1, 1, 1, 1, 0,  1, 1, 4'b0010, 1, 4'b1011, 1);
    tbl[19] = mk(1, 1, 2, 1, 0,  1, 1, 4'b0100, 1, 4'b1111, 1);
    tbl[20] = mk(1, 1, 3, 1, 0,  1, 1, 4'b1000, 0, 4'b1111, 1);
    tbl[21] = mk(1, 1, 0, 1, 0,  1, 1, 4'b0001, 0, 4'b1111, 1);
    tbl[22] = mk(1, 1, 1, 1, 0,  1, 1, 4'b0010, 0, 4'b1111, 1);
    tbl[23] = mk(1, 1, 2, 1, 0,  1, 1, 4'b0100, 0, 4'b1111, 1);
    tbl[24] = mk(1, 0, 0, 1, 0,  0, 0, 4'b0000, 0, 4'b1111, 1);
    tbl[25] = mk(1, 1, 1, 0, 1,  1, 1, 4'b0010, 1, 4'b0010, 1);
    tbl[26] = mk(1, 1, 2, 0, 0,  2, 1, 4'b0010, 1, 4'b0110, 0);
    tbl[27] = mk(0, 1, 3, 1, 0,  0, 0, 4'b0000, 0, 4'b0000, 1);
    tbl[28] = mk(1, 0, 0, 0, 0,  0, 0, 4'b0000, 0, 4'b0000, 1);

    @(negedge clk);
    for (int i = 0; i < NSTEP; i++) begin
      cur_step = i;
      apply(tbl[i].rst, tbl[i].iv, tbl[i].pos, tbl[i].ordy, tbl[i].clr);
      chk("count",     32'(bus.count),      32'(tbl[i].cnt));
      chk("out_valid", 32'(bus.out_valid),  32'(tbl[i].vld));
      chk("onehot",    32'(bus.out_onehot), 32'(tbl[i].oh));
      chk("out_new",   32'(bus.out_new),    32'(tbl[i].nw));
      chk("out_err",   32'(bus.out_err),    32'd0);
      chk("mask",      32'(bus.mask),       32'(tbl[i].msk));
      chk("in_ready",  32'(bus.in_ready),   32'(tbl[i].rdy));
    end

    // Randomized traffic with occasional clears and resets.
    mq.delete();
    mmask = 4'b0;
    for (int i = 0; i < 600; i++) begin
      logic r, iv, ordy, clr;
      int   pos;
      cur_step = 1000 + i;
      r    = ($urandom_range(0, 63) != 0);
      iv   = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 2) != 0);
      clr  = ($urandom_range(0, 11) == 0);
      pos  = int'($urandom_range(0, 3));
      if (!r) begin
        mq.delete();
        mmask = 4'b0;
      end else begin
        model_step(iv, pos, ordy, clr);
      end
      apply(r, iv, 2'(pos), ordy, clr);
      model_check();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
